// File: rtl/pong_game_ctrl.sv
// Match sequencer for two-player pong: game-flow FSM, scores, serve direction, point pause.
// Define PONG_AUTO_SERVE_EN to leave SERVE on the first frame_tick as well as on start.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 3,
  parameter int unsigned SCORE_W      = 2,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               game_over,
  output logic               winner
);

  localparam int unsigned CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle,
    StServe,
    StPlay,
    StPaused,
    StPointPause,
    StGameOver
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               win_q, win_d;
  logic               brst_q, brst_d;
  logic               auto_go;
  logic [SCORE_W-1:0] p1_inc, p2_inc;

`ifdef PONG_AUTO_SERVE_EN
  assign auto_go = frame_tick;
`else
  assign auto_go = 1'b0;
`endif

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == WIN_VAL) ? s : s + SCORE_W'(1);
  endfunction

  assign p1_inc = sat_inc(p1_q);
  assign p2_inc = sat_inc(p2_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      p1_q    <= '0;
      p2_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      win_q   <= 1'b0;
      brst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      brst_q  <= brst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    win_d   = win_q;
    brst_d  = 1'b0;
    unique case (state_q)
      // One start press from GAME_OVER begins a fresh match directly.
      StIdle, StGameOver: begin
        if (start) begin
          p1_d    = '0;
          p2_d    = '0;
          brst_d  = 1'b1;
          state_d = StServe;
        end
      end
      StServe: begin
        if (start || auto_go) state_d = StPlay;
      end
      StPlay: begin
        // Points beat start; p1 beats p2 when both arrive together.
        if (p1_point) begin
          p1_d   = p1_inc;
          dir_d  = 1'b1;
          brst_d = 1'b1;
          cnt_d  = '0;
          if (p1_inc == WIN_VAL) begin
            state_d = StGameOver;
            win_d   = 1'b0;
          end else begin
            state_d = StPointPause;
          end
        end else if (p2_point) begin
          p2_d   = p2_inc;
          dir_d  = 1'b0;
          brst_d = 1'b1;
          cnt_d  = '0;
          if (p2_inc == WIN_VAL) begin
            state_d = StGameOver;
            win_d   = 1'b1;
          end else begin
            state_d = StPointPause;
          end
        end else if (start) begin
          state_d = StPaused;
        end
      end
      StPaused: begin
        if (start) state_d = StPlay;
      end
      StPointPause: begin
        if (frame_tick) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = StServe;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ball_run   = (state_q == StPlay);
    game_over  = (state_q == StGameOver);
    ball_reset = brst_q;
    serve_dir  = dir_q;
    p1_score   = p1_q;
    p2_score   = p2_q;
    winner     = win_q;
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised bench for pong_game_ctrl against a phase-based reference model.
module tb_pong_game_ctrl;

  localparam int WIN    = 3;
  localparam int PAUSE  = 60;

  logic       CLK = 1'b0;
  logic       RST, start, frame_tick, p1_point, p2_point;
  logic       ball_run, ball_reset, serve_dir, game_over, winner;
  logic [1:0] p1_score, p2_score;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase names, scores and a countdown of remaining pause ticks.
  typedef enum int {MIdle, MServe, MPlay, MPaused, MPause, MOver} phase_e;
  phase_e m_phase;
  int     m_s1, m_s2, m_left;
  bit     m_dir, m_win, m_brst;

  pong_game_ctrl #(
    .WIN_SCORE   (WIN),
    .SCORE_W     (2),
    .PAUSE_FRAMES(PAUSE)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .frame_tick(frame_tick),
    .p1_point  (p1_point),
    .p2_point  (p2_point),
    .ball_run  (ball_run),
    .ball_reset(ball_reset),
    .serve_dir (serve_dir),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit st, input bit ft, input bit a, input bit b, input bit r);
    bit auto_serve;
`ifdef PONG_AUTO_SERVE_EN
    auto_serve = 1'b1;
`else
    auto_serve = 1'b0;
`endif
    if (r) begin
      m_phase = MIdle; m_s1 = 0; m_s2 = 0; m_left = 0;
      m_dir = 0; m_win = 0; m_brst = 0;
      return;
    end
    m_brst = 0;
    case (m_phase)
      MIdle, MOver: if (st) begin
        m_s1 = 0; m_s2 = 0; m_brst = 1; m_phase = MServe;
      end
      MServe: if (st || (auto_serve && ft)) m_phase = MPlay;
      MPlay: begin
        if (a || b) begin
          int sc;
          if (a) begin m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1; sc = m_s1; end
          else   begin m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2; sc = m_s2; end
          m_dir  = a;
          m_brst = 1;
          if (sc == WIN) begin
            m_phase = MOver;
            m_win   = !a;
          end else begin
            m_phase = MPause;
            m_left  = PAUSE;
          end
        end else if (st) begin
          m_phase = MPaused;
        end
      end
      MPaused: if (st) m_phase = MPlay;
      MPause: if (ft) begin
        m_left--;
        if (m_left == 0) m_phase = MServe;
      end
      default: m_phase = MIdle;
    endcase
  endtask

  // Drive one cycle of inputs, advance the model with the edge, compare all outputs after it.
  task automatic step(input bit st, input bit ft, input bit a, input bit b, input bit r);
    start = st; frame_tick = ft; p1_point = a; p2_point = b; RST = r;
    @(posedge CLK);
    model_step(st, ft, a, b, r);
    #1;
    check_eq("ball_run",   32'(ball_run),   32'(m_phase == MPlay));
    check_eq("ball_reset", 32'(ball_reset), 32'(m_brst));
    check_eq("serve_dir",  32'(serve_dir),  32'(m_dir));
    check_eq("p1_score",   32'(p1_score),   32'(m_s1));
    check_eq("p2_score",   32'(p2_score),   32'(m_s2));
    check_eq("game_over",  32'(game_over),  32'(m_phase == MOver));
    check_eq("winner",     32'(winner),     32'(m_win));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  initial begin
    m_phase = MIdle; m_s1 = 0; m_s2 = 0; m_left = 0; m_dir = 0; m_win = 0; m_brst = 0;
    start = 0; frame_tick = 0; p1_point = 0; p2_point = 0; RST = 1;
    #2;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_eq("reset_run", 32'(ball_run), 32'd0);

    // Match start, serve, first point, pause.
    step(1, 0, 0, 0, 0);
    check_eq("start_brst", 32'(ball_reset), 32'd1);
    step(0, 0, 0, 0, 0);
    check_eq("brst_1cyc", 32'(ball_reset), 32'd0);
    step(1, 0, 0, 0, 0);
    check_eq("serve_play", 32'(ball_run), 32'd1);
    step(0, 0, 1, 0, 0);
    check_eq("p1_pt", 32'(p1_score), 32'd1);
    check_eq("p1_dir", 32'(serve_dir), 32'd1);
    step(1, 0, 0, 0, 0);       // start ignored in pause
    ticks(PAUSE);
    step(1, 0, 0, 0, 0);
    // Simultaneous points, then start colliding with a point.
    step(0, 0, 1, 1, 0);
    check_eq("both_p2", 32'(p2_score), 32'd0);
    ticks(PAUSE);
    step(1, 0, 0, 0, 0);
    // Player 2 wins three straight.
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1, 0);
      if (k < 2) begin
        ticks(PAUSE);
        step(1, 0, 0, 0, 0);
      end
    end
    check_eq("over_flag", 32'(game_over), 32'd1);
    check_eq("over_win", 32'(winner), 32'd1);
    step(0, 0, 1, 1, 0);
    check_eq("over_frz", 32'(p2_score), 32'd3);
    step(1, 0, 0, 0, 0);
    check_eq("restart_p2", 32'(p2_score), 32'd0);
    // Pause/resume with ignored point.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check_eq("paused_pt", 32'(p1_score), 32'd0);
    step(1, 0, 0, 0, 0);
    check_eq("resume_nobrst", 32'(ball_reset), 32'd0);
    // Reset mid-pause, then confirm a full pause length is needed again.
    step(0, 0, 1, 0, 0);
    ticks(30);
    step(0, 1, 0, 0, 1);
    check_eq("rst_p1", 32'(p1_score), 32'd0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    ticks(PAUSE - 1);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 8) == 0, ($urandom % 2) == 0, ($urandom % 12) == 0,
           ($urandom % 12) == 0, ($urandom % 700) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Match sequencer for the two-player pong game. It owns the game-flow state machine, the scores, the serve direction and the between-point pause. It turns the debounced start pulse, the frame tick and the ball's point events into run/reset commands for the ball datapath and score outputs for the 7-segment refresher. It sits between the debouncer/VGA frame tick and the ball, paddle and score blocks, and replaces the ad-hoc start/stop toggle in the top level.

## Interface
Parameters:
- WIN_SCORE, 3: score that ends the match; must fit in SCORE_W bits.
- SCORE_W, 2: width of each score register.
- PAUSE_FRAMES, 60: frame ticks spent in POINT_PAUSE after each point.

Ports:
- CLK  in  1  system clock (12 MHz); single clock domain.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle debounced start/pause pulse.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- p1_point  in  1  one-cycle pulse: ball passed player 2's edge, so player 1 scores.
- p2_point  in  1  one-cycle pulse: ball passed player 1's edge, so player 2 scores.
- ball_run  out  1  ball may move; high only in PLAY.
- ball_reset  out  1  one-cycle pulse that re-centres the ball.
- serve_dir  out  1  direction of the next serve: 0 = toward player 1, 1 = toward player 2.
- p1_score  out  SCORE_W  player 1 score.
- p2_score  out  SCORE_W  player 2 score.
- game_over  out  1  high in GAME_OVER.
- winner  out  1  valid while game_over is high: 0 = player 1, 1 = player 2.

## Operation
- States: IDLE, SERVE, PLAY, PAUSED, POINT_PAUSE, GAME_OVER.
- Reset values: state IDLE, ball_run 0, ball_reset 0, serve_dir 0, scores 0, game_over 0, winner 0, pause counter 0.
- IDLE -> SERVE on start.
  - Clears both scores.
  - Pulses ball_reset.
- SERVE -> PLAY on start.
  - When PONG_AUTO_SERVE_EN is defined, SERVE -> PLAY also happens on the first frame_tick.
- PLAY -> PAUSED on start; PAUSED -> PLAY on start.
  - Ball position is held while paused, with no ball_reset.
- PLAY, on p1_point or p2_point:
  - Increment the scorer's score.
  - Set serve_dir toward the player who conceded (p1_point gives serve_dir 1).
  - Pulse ball_reset.
  - If the new score equals WIN_SCORE, go to GAME_OVER with winner set to the scorer. Otherwise go to POINT_PAUSE with the counter cleared.
- Simultaneous p1_point and p2_point: p1_point wins and p2_point is dropped.
- Point pulses are ignored in every state except PLAY.
- POINT_PAUSE:
  - The counter increments on each frame_tick.
  - When the counter reaches PAUSE_FRAMES-1 and a frame_tick arrives, go to SERVE.
  - start is ignored in this state.
- GAME_OVER:
  - Scores and winner are frozen.
  - start -> IDLE; that transition performs the IDLE->SERVE actions in the same step, so one press starts a new match.
- start arriving in the same cycle as a point in PLAY: the point takes priority and the start is dropped.
- Scores saturate at WIN_SCORE and never wrap.
- Pause counter width is $clog2(PAUSE_FRAMES).
- RST asserted in any state, including mid-pause, returns all registers to their reset values on the next edge.

## Timing
- All outputs are registered and change on the CLK edge that samples the triggering input. Latency is 1 cycle from input pulse to the state or output change.
- ball_reset is high for exactly 1 cycle per point and per match start.
- ball_run deasserts in the same cycle that state leaves PLAY, so the ball never moves during the point cycle's successor.
- Score increments are visible in the cycle after the point pulse.
- game_over rises in that same cycle when the winning score is reached.
- Pause duration is PAUSE_FRAMES frame ticks: about 1 s at 60 Hz with defaults.
- Inputs are expected to be single-cycle pulses. A level held for N cycles counts as N events, except in PLAY, where the first point moves the state out of PLAY.

## Configuration
- PONG_AUTO_SERVE_EN defined: SERVE leaves to PLAY on the first frame_tick, so the game restarts automatically after each point. start in SERVE still works.
- PONG_AUTO_SERVE_EN undefined: SERVE waits indefinitely for start. This is the default build.

## Test plan
- Reset, start -> the cycle after start: state SERVE, ball_reset pulse for 1 cycle, scores 0/0, ball_run 0. A second start -> ball_run 1 the next cycle.
- PLAY, p1_point -> p1_score 1, serve_dir 1, ball_reset pulse, ball_run 0. After 60 frame_ticks -> SERVE. With PONG_AUTO_SERVE_EN defined, PLAY follows on the 61st tick.
- PLAY, p1_point and p2_point in the same cycle -> p1_score +1, p2_score unchanged.
- p2 scores three times -> p2_score 3, game_over 1, winner 1, ball_run 0. Further point pulses leave the scores at 0/3. start -> scores 0/0, state SERVE.
- PLAY, start -> PAUSED, ball_run 0, p1_point ignored. start -> PLAY with no ball_reset.
- RST during POINT_PAUSE at counter 30 -> next cycle: IDLE, scores 0, counter 0, all outputs at reset values.
